// File: rtl/ps_pkg.sv
// Shared program-sequencer definitions: STKY bit positions, ureg addresses
// and the PC-stack operation encoding. Used by ps_pcstck_ctl.
package ps_pkg;

   localparam int unsigned STKY_EMPTY = 0;
   localparam int unsigned STKY_FULL  = 1;
   localparam int unsigned STKY_OVF   = 2;
   localparam int unsigned STKY_UFLW  = 3;

   localparam logic [4:0] UREG_PCSTK  = 5'b00100;
   localparam logic [4:0] UREG_PCSTKP = 5'b00101;
   localparam logic [4:0] UREG_STKY   = 5'b11110;

   // One resolved operation per cycle after priority decode.
   typedef enum logic [2:0] {
      STCK_OP_NONE = 3'd0,
      STCK_OP_PUSH = 3'd1,
      STCK_OP_POP  = 3'd2,
      STCK_OP_REPL = 3'd3,
      STCK_OP_WR   = 3'd4
   } stck_op_e;

endpackage : ps_pkg

// File: rtl/ps_stck_mem.sv
// DEPTH x ADDR_W register array for the PC stack: one synchronous write
// port, one combinational read port, cleared by asynchronous reset.
module ps_stck_mem #(
   parameter int ADDR_W = 16,
   parameter int DEPTH  = 4,
   parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en_i,
   input  logic [IDX_W-1:0]  wr_addr_i,
   input  logic [ADDR_W-1:0] wr_dt_i,
   input  logic [IDX_W-1:0]  rd_addr_i,
   output logic [ADDR_W-1:0] rd_dt_o
);

   logic [ADDR_W-1:0] mem_q [DEPTH];

   // NOTE: this array is deliberately reset - the sequencer reads mem[0] while
   // the stack is empty, so its post-reset contents are architecturally visible.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_dt_i;
      end
   end

   assign rd_dt_o = mem_q[rd_addr_i];

endmodule : ps_stck_mem

// File: rtl/ps_pcstck_ctl.sv
// PC stack controller: pointer, push/pop/replace/ureg-write priority and the
// sticky ovf/uflw bits. Define PS_STCK_UFLW_EN to build the underflow flag.
module ps_pcstck_ctl
   import ps_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DEPTH  = 4,
   parameter int PTR_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] push_dt,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_dt,
   input  logic              clr_stcky,
   output logic [ADDR_W-1:0] rd_dt,
   output logic [PTR_W-1:0]  ptr,
   output logic [3:0]        stcky
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] FULL_PTR = PTR_W'(DEPTH);
   localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);

   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic              ovf_q, ovf_d, ovf_set;
   logic              uflw;
   logic              empty, full;
   logic [IDX_W-1:0]  top_idx;
   stck_op_e          op;
   logic              mem_we;
   logic [IDX_W-1:0]  mem_wa;
   logic [ADDR_W-1:0] mem_wd;

   assign empty   = (ptr_q == '0);
   assign full    = (ptr_q == FULL_PTR);
   assign top_idx = empty ? '0 : IDX_W'(ptr_q - ONE_PTR);

   // push+pop on an empty stack degenerates to a plain push; wr_en only
   // takes effect when neither push nor pop is requested.
   always_comb begin
      if (push && pop && !empty) op = STCK_OP_REPL;
      else if (push)             op = STCK_OP_PUSH;
      else if (pop)              op = STCK_OP_POP;
      else if (wr_en)            op = STCK_OP_WR;
      else                       op = STCK_OP_NONE;
   end

   // NOTE: every output of this block gets a default first, so no path
   // through the case can leave one unassigned and infer a latch.
   always_comb begin
      ptr_d   = ptr_q;
      mem_we  = 1'b0;
      mem_wa  = top_idx;
      mem_wd  = push_dt;
      ovf_set = 1'b0;
      unique case (op)
         STCK_OP_PUSH: begin
            if (full) begin
               ovf_set = 1'b1;
            end else begin
               mem_we = 1'b1;
               mem_wa = IDX_W'(ptr_q);
               ptr_d  = ptr_q + ONE_PTR;
            end
         end
         STCK_OP_POP: begin
            if (!empty) ptr_d = ptr_q - ONE_PTR;
         end
         STCK_OP_REPL: mem_we = 1'b1;
         STCK_OP_WR: begin
            mem_we = 1'b1;
            mem_wd = wr_dt;
         end
         default: ;
      endcase
      ovf_d = ovf_set | (ovf_q & ~clr_stcky);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
         ovf_q <= ovf_d;
      end
   end

`ifdef PS_STCK_UFLW_EN
   logic uflw_q, uflw_d, uflw_set;

   assign uflw_set = (op == STCK_OP_POP) && empty;
   assign uflw_d   = uflw_set | (uflw_q & ~clr_stcky);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) uflw_q <= 1'b0;
      else      uflw_q <= uflw_d;
   end

   assign uflw = uflw_q;
`else
   assign uflw = 1'b0;
`endif

   ps_stck_mem #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_mem (
      .clk       (clk),
      .rst_n     (rst),
      .wr_en_i   (mem_we),
      .wr_addr_i (mem_wa),
      .wr_dt_i   (mem_wd),
      .rd_addr_i (top_idx),
      .rd_dt_o   (rd_dt)
   );

   assign ptr                = ptr_q;
   assign stcky[STKY_UFLW]   = uflw;
   assign stcky[STKY_OVF]    = ovf_q;
   assign stcky[STKY_FULL]   = full;
   assign stcky[STKY_EMPTY]  = empty;

endmodule : ps_pcstck_ctl

// File: tb/tb_ps_pcstck_ctl.sv
// Scoreboard bench for ps_pcstck_ctl (DEPTH=4, ADDR_W=16): directed scenarios
// then random traffic, checked against a behavioural stack model.
module tb_ps_pcstck_ctl;

   localparam int ADDR_W = 16;
   localparam int DEPTH  = 4;
   localparam int PTR_W  = $clog2(DEPTH + 1);

`ifdef PS_STCK_UFLW_EN
   localparam bit UF_EN = 1'b1;
`else
   localparam bit UF_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              push = 1'b0, pop = 1'b0, wr_en = 1'b0, clr_stcky = 1'b0;
   logic [ADDR_W-1:0] push_dt = '0, wr_dt = '0;
   logic [ADDR_W-1:0] rd_dt;
   logic [PTR_W-1:0]  ptr;
   logic [3:0]        stcky;

   ps_pcstck_ctl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .push(push), .pop(pop), .push_dt(push_dt),
      .wr_en(wr_en), .wr_dt(wr_dt), .clr_stcky(clr_stcky),
      .rd_dt(rd_dt), .ptr(ptr), .stcky(stcky)
   );

   always #5 clk = ~clk;

   typedef struct {
      string             tag;
      logic [ADDR_W-1:0] rd;
      logic [PTR_W-1:0]  cnt;
      logic [3:0]        sty;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // Behavioural model: storage array, entry count, sticky flags.
   logic [ADDR_W-1:0] m_mem [DEPTH];
   int                m_cnt;
   bit                m_ovf, m_uflw;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_cnt  = 0;
      m_ovf  = 1'b0;
      m_uflw = 1'b0;
   endfunction

   function automatic exp_t model_view(input string tag);
      exp_t e;
      e.tag = tag;
      e.rd  = m_mem[(m_cnt == 0) ? 0 : m_cnt - 1];
      e.cnt = PTR_W'(m_cnt);
      e.sty = {m_uflw, m_ovf, m_cnt == DEPTH, m_cnt == 0};
      return e;
   endfunction

   function automatic void model_step(input bit pu, input bit po, input logic [ADDR_W-1:0] pd,
                                      input bit we, input logic [ADDR_W-1:0] wd, input bit clr);
      bit ov_ev = 1'b0, uf_ev = 1'b0;
      if (pu && po) begin
         if (m_cnt == 0) begin m_mem[0] = pd; m_cnt = 1; end
         else m_mem[m_cnt-1] = pd;
      end else if (pu) begin
         if (m_cnt == DEPTH) ov_ev = 1'b1;
         else begin m_mem[m_cnt] = pd; m_cnt++; end
      end else if (po) begin
         if (m_cnt == 0) uf_ev = 1'b1;
         else m_cnt--;
      end else if (we) begin
         m_mem[(m_cnt == 0) ? 0 : m_cnt - 1] = wd;
      end
      m_ovf  = ov_ev | (m_ovf & ~clr);
      m_uflw = UF_EN & (uf_ev | (m_uflw & ~clr));
   endfunction

   // One cycle of stimulus; the expected post-edge view goes to the scoreboard.
   task automatic do_op(input string tag, input bit pu, input bit po, input logic [ADDR_W-1:0] pd,
                        input bit we, input logic [ADDR_W-1:0] wd, input bit clr);
      @(negedge clk);
      push = pu; pop = po; push_dt = pd; wr_en = we; wr_dt = wd; clr_stcky = clr;
      @(posedge clk);
      model_step(pu, po, pd, we, wd, clr);
      exp_q.push_back(model_view(tag));
   endtask

   task automatic idle();
      do_op("idle", 0, 0, '0, 0, '0, 0);
   endtask

   // Asynchronous reset pulse placed between edges; outputs checked before any edge.
   task automatic async_reset(input string tag);
      @(negedge clk);
      push = 0; pop = 0; wr_en = 0; clr_stcky = 0;
      #2 rst = 1'b0;
      #1;
      check({tag, "_ptr"},   32'(ptr),   32'd0);
      check({tag, "_stcky"}, 32'(stcky), 32'b0001);
      check({tag, "_rd"},    32'(rd_dt), 32'h0);
      #1 rst = 1'b1;
      model_reset();
   endtask

   // Monitor: outputs are sampled on the falling edge, away from the update edge.
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check({e.tag, "_rd"},    32'(rd_dt), 32'(e.rd));
         check({e.tag, "_ptr"},   32'(ptr),   32'(e.cnt));
         check({e.tag, "_stcky"}, 32'(stcky), 32'(e.sty));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      #12 rst = 1'b1;
      check("reset_ptr",   32'(ptr),   32'd0);
      check("reset_stcky", 32'(stcky), 32'b0001);
      check("reset_rd",    32'(rd_dt), 32'h0);
      idle();

      do_op("push1", 1, 0, 16'h0010, 0, '0, 0);
      do_op("push2", 1, 0, 16'h0020, 0, '0, 0);
      do_op("push3", 1, 0, 16'h0030, 0, '0, 0);
      do_op("push4", 1, 0, 16'h0040, 0, '0, 0);
      do_op("push_ovf", 1, 0, 16'h0050, 0, '0, 0);

      async_reset("rst1");
      do_op("push_a", 1, 0, 16'h0010, 0, '0, 0);
      do_op("push_b", 1, 0, 16'h0020, 0, '0, 0);
      do_op("repl", 1, 1, 16'h0099, 0, '0, 0);
      do_op("pop_a", 0, 1, '0, 0, '0, 0);
      do_op("pop_b", 0, 1, '0, 0, '0, 0);
      do_op("pop_empty", 0, 1, '0, 0, '0, 0);
      do_op("clr", 0, 0, '0, 0, '0, 1);
      do_op("pushpop_empty", 1, 1, 16'h0077, 0, '0, 0);
      do_op("pop_c", 0, 1, '0, 0, '0, 0);
      do_op("wr_empty", 0, 0, '0, 1, 16'h5A5A, 0);

      async_reset("rst2");
      do_op("push_c", 1, 0, 16'h0010, 0, '0, 0);
      do_op("wr_top", 0, 0, '0, 1, 16'hABCD, 0);
      do_op("wr_push", 1, 0, 16'h2222, 1, 16'h1111, 0);
      do_op("pop_d", 0, 1, '0, 0, '0, 0);
      do_op("wr_pop", 0, 1, '0, 1, 16'hDEAD, 0);

      for (int i = 0; i < 4; i++) do_op("fill", 1, 0, 16'(16'h0100 + i), 0, '0, 0);
      do_op("ovf_set", 1, 0, 16'h0F00, 0, '0, 0);
      do_op("clr_with_ovf", 1, 0, 16'h0F01, 0, '0, 1);
      do_op("clr_only", 0, 0, '0, 0, '0, 1);
      do_op("pop_e", 0, 1, '0, 0, '0, 0);
      async_reset("rst_mid");
      idle();

      for (int i = 0; i < 400; i++) begin
         int unsigned r = $urandom_range(0, 99);
         bit pu  = (r < 40) || (r >= 90);
         bit po  = (r >= 40 && r < 75) || (r >= 90);
         bit we  = ($urandom_range(0, 3) == 0);
         bit clr = ($urandom_range(0, 15) == 0);
         do_op("rand", pu, po, 16'($urandom), we, 16'($urandom), clr);
      end

      idle();
      @(negedge clk);
      @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_ps_pcstck_ctl

// File: doc/ps_pcstck_ctl.md
# ps_pcstck_ctl

Parametrised PC stack controller for the program sequencer. It replaces the fixed two-entry stack with a DEPTH-entry, ADDR_W-wide LIFO. It supports push, pop, simultaneous push+pop (replace top), and universal-register read/write of the top-of-stack. It maintains the stack pointer and the sticky status bits that the sequencer exposes as the PCSTKP and STKY registers.

## Interface
- ADDR_W, 16, width of a stacked PC value
- DEPTH, 4, number of stack entries (≥2)
- PTR_W, $clog2(DEPTH+1), pointer width (derived; do not override)
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset; one clock, reset asynchronous and active-low
- push  in  1  push push_dt this cycle
- pop  in  1  pop top entry this cycle
- push_dt  in  ADDR_W  value to push (return address)
- wr_en  in  1  ureg write to top-of-stack (PCSTK)
- wr_dt  in  ADDR_W  ureg write data
- clr_stcky  in  1  clear sticky error bits (ovf, uflw)
- rd_dt  out  ADDR_W  current top-of-stack value
- ptr  out  PTR_W  entry count, 0..DEPTH
- stcky  out  4  {uflw, ovf, full, empty}

## Operation
- State: storage mem[0..DEPTH-1], ptr, sticky regs ovf and uflw. Outputs empty and full are decoded from ptr: empty = (ptr==0), full = (ptr==DEPTH).
- Push, not full: mem[ptr] <= push_dt; ptr <= ptr+1.
- Push, full: no write, ptr unchanged, ovf <= 1.
- Pop, not empty: ptr <= ptr-1; storage is untouched.
- Pop, empty: ptr unchanged; uflw <= 1 (macro-dependent, see Configuration).
- Push and pop together, not empty: replace top, mem[ptr-1] <= push_dt, ptr unchanged, no flags set.
- Push and pop together, empty: treated as a plain push; no uflw.
- wr_en alone: writes wr_dt to mem[ptr-1] when not empty, or to mem[0] when empty. ptr is unchanged.
- wr_en together with push or pop: wr_en is ignored, and push/pop has priority.
- rd_dt is combinational from registered state: mem[ptr-1] when not empty, mem[0] when empty.
- Sticky bits:
  - clr_stcky clears ovf and uflw.
  - If a new error event occurs in the same cycle as clr_stcky, the set wins.
  - Sticky bits are otherwise held until reset.
- Pointer arithmetic is PTR_W bits and never wraps; the boundary checks above prevent wrap.

## Timing
- Reset values: ptr=0, every mem entry=0, ovf=0, uflw=0. Therefore rd_dt=0 and stcky=4'b0001.
- Reset asserted mid-operation clears all state asynchronously. Any push/pop pending in that cycle is lost.
- Write/pop latency is 1 cycle: rd_dt, ptr and stcky reflect an operation after the edge that samples it.
- No combinational path from push, pop or wr_dt to rd_dt.
- Inputs need only be valid at the sampling edge. There is no handshake: every accepted operation completes in one cycle, and a rejected one is flagged via sticky.
- Back-to-back operations every cycle are supported.

## Configuration
- PS_STCK_UFLW_EN defined: uflw register is present, and pop-on-empty sets stcky[3].
- PS_STCK_UFLW_EN not defined:
  - no uflw register; stcky[3] is tied 0;
  - pop-on-empty is silently ignored;
  - clr_stcky affects ovf only.
- Port list and widths are identical in both builds.

## Structure
- Shared package ps_pkg holds:
  - STKY bit index constants: EMPTY=0, FULL=1, OVF=2, UFLW=3.
  - Ureg address constants: PCSTK=5'b00100, PCSTKP=5'b00101, STKY=5'b11110.
- One sub-module, ps_stck_mem: DEPTH×ADDR_W register array with async-reset clear, one write port (addr, data, en) and one combinational read port.
- ps_pcstck_ctl contains the pointer, decode/priority logic and the sticky registers.

## Test plan
All scenarios use DEPTH=4 and ADDR_W=16.
- Reset, then idle -> rd_dt=16'h0000, ptr=0, stcky=4'b0001.
- Push 16'h0010, 16'h0020, 16'h0030, 16'h0040 on consecutive cycles -> ptr=4, stcky=4'b0010, rd_dt=16'h0040. A fifth push of 16'h0050 -> ptr=4, rd_dt=16'h0040, stcky=4'b0110.
- Stack holds 16'h0010, 16'h0020; push 16'h0099 with pop in the same cycle -> ptr=2, rd_dt=16'h0099. Pop -> rd_dt=16'h0010, ptr=1.
- Empty stack; pop -> with PS_STCK_UFLW_EN, stcky=4'b1001; without it, stcky=4'b0001. Then clr_stcky -> stcky=4'b0001.
- Stack holds 16'h0010; wr_en with wr_dt=16'hABCD -> rd_dt=16'hABCD, ptr=1. wr_en with wr_dt=16'h1111 and push 16'h2222 in the same cycle -> rd_dt=16'h2222, ptr=2, mem[0]=16'hABCD.
- Stack full with ovf set; clr_stcky together with another push -> ovf remains 1. rst pulsed low mid-sequence -> ptr=0, stcky=4'b0001 immediately, without waiting for a clock edge.
